gfx_pattern_gen: RTL and testbench

Parametrised graphics pixel-stream generator driving the `gfx_x`/`gfx_y`/`gfx_color`/`gfx_valid`/`gfx_ready` write port of the stripe frame-buffer path. It produces whole frames in one of four modes: linear, strided, pseudo-random and solid fill. Frame count is programmable, and it reports frame boundaries. It is used as a bring-up and self-test source in front of `gfx_vga_stripe`, and as a bus-contention stress source.

---
 rtl/gfx_pattern_pkg.sv | 9 +
 rtl/gfx_lfsr16.sv | 20 ++
 rtl/gfx_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_gfx_pattern_gen.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pattern_pkg.sv
// gfx_pattern_pkg: shared mode/state types and LFSR step for the pattern generator
package gfx_pattern_pkg;
    typedef enum logic [1:0] {LINEAR, STRIDE, RANDOM, SOLID} gfx_pattern_mode_t;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} gfx_pattern_state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
endpackage

// File: rtl/gfx_lfsr16.sv
// gfx_lfsr16: 16-bit Galois LFSR with seed load and single-step advance
module gfx_lfsr16 import gfx_pattern_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= SEED;
        else if (load)
            q <= seed;
        else if (advance)
            q <= lfsr_next(q);
    end
endmodule

// File: rtl/gfx_pattern_gen.sv
// gfx_pattern_gen: frame pixel-stream generator (linear, stride, random, solid) with frame accounting
module gfx_pattern_gen import gfx_pattern_pkg::*; #(
    parameter int          FB_WIDTH       = 16,
    parameter int          FB_HEIGHT      = 8,
    parameter int          PIXEL_BITS     = 12,
    parameter int          FRAME_CNT_BITS = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [$clog2(FB_WIDTH)-1:0]  stride,
    input  logic [PIXEL_BITS-1:0]        fill_color,
    input  logic [FRAME_CNT_BITS-1:0]    frames,
    output logic [$clog2(FB_WIDTH)-1:0]  gfx_x,
    output logic [$clog2(FB_HEIGHT)-1:0] gfx_y,
    output logic [PIXEL_BITS-1:0]        gfx_color,
    output logic                         gfx_valid,
    input  logic                         gfx_ready,
    output logic                         busy,
    output logic                         frame_done,
    output logic [FRAME_CNT_BITS-1:0]    frame_cnt
);
    localparam int XW = $clog2(FB_WIDTH);
    localparam int YW = $clog2(FB_HEIGHT);
    localparam int NPIX = FB_WIDTH * FB_HEIGHT;
    localparam int PW = $clog2(NPIX);
    localparam logic [XW:0] W_LIM = (XW+1)'(FB_WIDTH);
    localparam logic [YW:0] H_LIM = (YW+1)'(FB_HEIGHT);
    localparam logic [XW:0] ONE_STEP = (XW+1)'(1);

    gfx_pattern_state_t state_q, state_d;
    gfx_pattern_mode_t mode_l, src_mode;
    logic [XW-1:0] stride_l, stride_eff, geo_x, nx;
    logic [YW-1:0] geo_y, ny;
    logic [PIXEL_BITS-1:0] fill_l, src_fill, ncolor;
    logic [FRAME_CNT_BITS-1:0] frames_l;
    logic [PW-1:0] pix_cnt;
    logic [XW:0] step;
    logic [15:0] lfsr_q, cand;
    logic eol, last, xfer, stop, start, wrap, bubble, load, adv, nok, cur_ok, valid_d;

    function automatic logic in_range(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return ({1'b0, px} < W_LIM) && ({1'b0, py} < H_LIM);
    endfunction

    function automatic logic [PIXEL_BITS-1:0] pix_color(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return PIXEL_BITS'(32'(py) * FB_WIDTH + 32'(px));
    endfunction

    gfx_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk(clk),
        .reset(reset),
        .seed(LFSR_SEED),
        .load(start),
        .advance(adv),
        .q(lfsr_q)
    );

    assign busy = (state_q != IDLE);

    always_comb begin
        xfer = gfx_valid && gfx_ready;
        start = (state_q == IDLE) && enable;
        stride_eff = (stride_l == '0) ? XW'(1) : stride_l;
        step = {1'b0, gfx_x} + ((mode_l == STRIDE) ? {1'b0, stride_eff} : ONE_STEP);
        eol = step >= W_LIM;
        last = (mode_l == RANDOM) ? (pix_cnt == PW'(NPIX - 1)) : (eol && gfx_y == YW'(FB_HEIGHT - 1));
        wrap = xfer && last;
        stop = wrap && frames_l != '0 && frame_cnt + 1'b1 == frames_l;
        bubble = (state_q == RUN) && !gfx_valid && enable;
        load = start || (xfer && !stop) || bubble;
        src_mode = (start || wrap) ? gfx_pattern_mode_t'(mode) : mode_l;
        src_fill = (start || wrap) ? fill_color : fill_l;
        cand = start ? LFSR_SEED : lfsr_next(lfsr_q);
        geo_x = (start || wrap || eol) ? '0 : step[XW-1:0];
        geo_y = (start || wrap) ? '0 : (eol ? gfx_y + 1'b1 : gfx_y);
        nx = (src_mode == RANDOM) ? cand[XW-1:0] : geo_x;
        ny = (src_mode == RANDOM) ? cand[XW +: YW] : geo_y;
        nok = in_range(nx, ny);
        ncolor = (src_mode == SOLID) ? src_fill : pix_color(nx, ny);
        adv = load && !start && src_mode == RANDOM;
        cur_ok = in_range(gfx_x, gfx_y);
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enable ? RUN : IDLE;
            RUN:     state_d = stop ? IDLE : (((xfer || !gfx_valid) && !enable) ? PAUSE : RUN);
            PAUSE:   state_d = enable ? RUN : PAUSE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == RUN) && (load ? nok : ((state_q == PAUSE) ? cur_ok : gfx_valid));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gfx_x <= '0;
            gfx_y <= '0;
            gfx_color <= '0;
            gfx_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt <= '0;
            pix_cnt <= '0;
            mode_l <= LINEAR;
            stride_l <= '0;
            fill_l <= '0;
            frames_l <= '0;
        end else begin
            frame_done <= wrap;
            gfx_valid <= valid_d;
            if (start)
                frame_cnt <= '0;
            else if (wrap)
                frame_cnt <= frame_cnt + 1'b1;
            if (start || wrap)
                pix_cnt <= '0;
            else if (xfer)
                pix_cnt <= pix_cnt + 1'b1;
            if (start || wrap) begin
                mode_l <= gfx_pattern_mode_t'(mode);
                stride_l <= stride;
                fill_l <= fill_color;
            end
            if (start)
                frames_l <= frames;
            if (load) begin
                gfx_x <= nx;
                gfx_y <= ny;
                gfx_color <= ncolor;
            end
        end
    end
endmodule

// File: tb/tb_gfx_pattern_gen.sv
// tb_gfx_pattern_gen: directed self-checking bench for gfx_pattern_gen
module tb_gfx_pattern_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  stride = 4'd0;
    logic [11:0] fill_color = 12'h000;
    logic [7:0]  frames = 8'd1;
    logic [3:0]  gfx_x;
    logic [2:0]  gfx_y;
    logic [11:0] gfx_color;
    logic        gfx_valid;
    logic        gfx_ready = 1'b1;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    int vec = 0;
    int err = 0;

    gfx_pattern_gen dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .mode(mode),
        .stride(stride),
        .fill_color(fill_color),
        .frames(frames),
        .gfx_x(gfx_x),
        .gfx_y(gfx_y),
        .gfx_color(gfx_color),
        .gfx_valid(gfx_valid),
        .gfx_ready(gfx_ready),
        .busy(busy),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_lfsr(input logic [15:0] v);
        logic b;
        b = v[0];
        v = v >> 1;
        if (b)
            v = v ^ 16'hB400;
        return v;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        vec++;
        if ({gfx_x, gfx_y, gfx_color} !== 19'd0) begin
            err++;
            $display("FAIL reset_payload got %h want 0", {gfx_x, gfx_y, gfx_color});
        end
        vec++;
        if (gfx_valid !== 1'b0) begin
            err++;
            $display("FAIL reset_valid got %b want 0", gfx_valid);
        end
        vec++;
        if ({busy, frame_done} !== 2'b00) begin
            err++;
            $display("FAIL reset_busy_done got %b want 00", {busy, frame_done});
        end
        vec++;
        if (frame_cnt !== 8'd0) begin
            err++;
            $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_linear;
        int n, cyc;
        logic [3:0] ex;
        logic [2:0] ey;
        logic [11:0] ec;
        mode = 2'd0;
        frames = 8'd1;
        gfx_ready = 1'b1;
        enable = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 128 && cyc < 400) begin
            tick;
            cyc++;
            if (gfx_valid) begin
                ex = 4'(n % 16);
                ey = 3'(n / 16);
                ec = 12'(n);
                vec++;
                if ({gfx_x, gfx_y, gfx_color} !== {ex, ey, ec}) begin
                    err++;
                    $display("FAIL lin_beat n=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", n, gfx_x, gfx_y, gfx_color, ex, ey, ec);
                end
                if (n == 127)
                    enable = 1'b0;
                n++;
            end
        end
        vec++;
        if (cyc !== 128) begin
            err++;
            $display("FAIL lin_cycles got %0d want 128", cyc);
        end
        tick;
        vec++;
        if ({frame_done, gfx_valid, busy, frame_cnt} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
            err++;
            $display("FAIL lin_end got done=%b valid=%b busy=%b cnt=%0d want 1 0 0 1", frame_done, gfx_valid, busy, frame_cnt);
        end
        tick;
        vec++;
        if (frame_done !== 1'b0) begin
            err++;
            $display("FAIL lin_done_pulse got %b want 0", frame_done);
        end
    endtask

    task automatic test_stride2;
        int n, k, cyc;
        logic [3:0] ex;
        logic [2:0] ey;
        mode = 2'd1;
        stride = 4'd2;
        frames = 8'd2;
        enable = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 128 && cyc < 400) begin
            tick;
            cyc++;
            if (gfx_valid) begin
                k = n % 64;
                ex = 4'((k % 8) * 2);
                ey = 3'(k / 8);
                vec++;
                if ({gfx_x, gfx_y, gfx_color} !== {ex, ey, 12'(ey * 16 + ex)}) begin
                    err++;
                    $display("FAIL str2_beat n=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", n, gfx_x, gfx_y, gfx_color, ex, ey, 12'(ey * 16 + ex));
                end
                vec++;
                if (frame_done !== (n == 64)) begin
                    err++;
                    $display("FAIL str2_done n=%0d got %b want %b", n, frame_done, n == 64);
                end
                if (n == 127)
                    enable = 1'b0;
                n++;
            end
        end
        vec++;
        if (cyc !== 128) begin
            err++;
            $display("FAIL str2_cycles got %0d want 128", cyc);
        end
        tick;
        vec++;
        if ({frame_done, gfx_valid, frame_cnt} !== {1'b1, 1'b0, 8'd2}) begin
            err++;
            $display("FAIL str2_end got done=%b valid=%b cnt=%0d want 1 0 2", frame_done, gfx_valid, frame_cnt);
        end
        tick;
    endtask

    task automatic test_stride3;
        int n, cyc;
        logic [3:0] ex;
        logic [2:0] ey;
        mode = 2'd1;
        stride = 4'd3;
        frames = 8'd1;
        enable = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 48 && cyc < 200) begin
            tick;
            cyc++;
            if (gfx_valid) begin
                ex = 4'((n % 6) * 3);
                ey = 3'(n / 6);
                vec++;
                if ({gfx_x, gfx_y, gfx_color} !== {ex, ey, 12'(ey * 16 + ex)}) begin
                    err++;
                    $display("FAIL str3_beat n=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", n, gfx_x, gfx_y, gfx_color, ex, ey, 12'(ey * 16 + ex));
                end
                if (n == 47)
                    enable = 1'b0;
                n++;
            end
        end
        tick;
        vec++;
        if ({frame_done, gfx_valid, frame_cnt, n} !== {1'b1, 1'b0, 8'd1, 48}) begin
            err++;
            $display("FAIL str3_end got done=%b valid=%b cnt=%0d beats=%0d want 1 0 1 48", frame_done, gfx_valid, frame_cnt, n);
        end
        tick;
    endtask

    task automatic test_backpressure;
        int n, cyc;
        logic [3:0] ex;
        logic [2:0] ey;
        mode = 2'd0;
        stride = 4'd0;
        frames = 8'd1;
        enable = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 128 && cyc < 1000) begin
            tick;
            gfx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            cyc++;
            if (gfx_valid) begin
                ex = 4'(n % 16);
                ey = 3'(n / 16);
                vec++;
                if ({gfx_x, gfx_y, gfx_color} !== {ex, ey, 12'(n)}) begin
                    err++;
                    $display("FAIL bp_beat n=%0d ready=%b got (%0d,%0d,%h) want (%0d,%0d,%h)", n, gfx_ready, gfx_x, gfx_y, gfx_color, ex, ey, 12'(n));
                end
                if (gfx_ready) begin
                    if (n == 127)
                        enable = 1'b0;
                    n++;
                end
            end
        end
        vec++;
        if (n !== 128) begin
            err++;
            $display("FAIL bp_count got %0d want 128", n);
        end
        tick;
        gfx_ready = 1'b1;
        vec++;
        if ({frame_done, gfx_valid, frame_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            err++;
            $display("FAIL bp_end got done=%b valid=%b cnt=%0d want 1 0 1", frame_done, gfx_valid, frame_cnt);
        end
        tick;
    endtask

    task automatic test_random;
        int n, cyc;
        logic [15:0] s;
        logic [3:0] ex;
        logic [2:0] ey;
        mode = 2'd2;
        frames = 8'd1;
        enable = 1'b1;
        s = 16'hACE1;
        n = 0;
        cyc = 0;
        while (n < 128 && cyc < 400) begin
            tick;
            cyc++;
            if (gfx_valid) begin
                ex = s[3:0];
                ey = s[6:4];
                vec++;
                if ({gfx_x, gfx_y, gfx_color} !== {ex, ey, 12'(ey * 16 + ex)}) begin
                    err++;
                    $display("FAIL rnd_beat n=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", n, gfx_x, gfx_y, gfx_color, ex, ey, 12'(ey * 16 + ex));
                end
                s = model_lfsr(s);
                if (n == 127)
                    enable = 1'b0;
                n++;
            end
        end
        vec++;
        if (cyc !== 128) begin
            err++;
            $display("FAIL rnd_cycles got %0d want 128", cyc);
        end
        tick;
        vec++;
        if ({frame_done, gfx_valid, frame_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            err++;
            $display("FAIL rnd_end got done=%b valid=%b cnt=%0d want 1 0 1", frame_done, gfx_valid, frame_cnt);
        end
        tick;
    endtask

    task automatic test_solid_pause_reset;
        int n, m, cyc;
        logic [3:0] ex;
        logic [2:0] ey;
        logic [11:0] ec;
        mode = 2'd3;
        fill_color = 12'hF00;
        frames = 8'd0;
        enable = 1'b1;
        n = 0;
        cyc = 0;
        while (n <= 40 && cyc < 100) begin
            tick;
            cyc++;
            if (gfx_valid) begin
                vec++;
                if ({gfx_x, gfx_y, gfx_color} !== {4'(n % 16), 3'(n / 16), 12'hF00}) begin
                    err++;
                    $display("FAIL sol_beat n=%0d got (%0d,%0d,%h) want (%0d,%0d,f00)", n, gfx_x, gfx_y, gfx_color, n % 16, n / 16);
                end
                if (n == 40)
                    enable = 1'b0;
                n++;
            end
        end
        tick;
        vec++;
        if ({gfx_valid, busy} !== 2'b01) begin
            err++;
            $display("FAIL pause_enter got valid=%b busy=%b want 0 1", gfx_valid, busy);
        end
        mode = 2'd0;
        repeat (3) tick;
        vec++;
        if ({gfx_valid, busy} !== 2'b01) begin
            err++;
            $display("FAIL pause_hold got valid=%b busy=%b want 0 1", gfx_valid, busy);
        end
        enable = 1'b1;
        cyc = 0;
        while (n < 148 && cyc < 300) begin
            tick;
            cyc++;
            if (gfx_valid) begin
                m = (n < 128) ? n : n - 128;
                ex = 4'(m % 16);
                ey = 3'(m / 16);
                ec = (n < 128) ? 12'hF00 : 12'(m);
                vec++;
                if ({gfx_x, gfx_y, gfx_color} !== {ex, ey, ec}) begin
                    err++;
                    $display("FAIL resume_beat n=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", n, gfx_x, gfx_y, gfx_color, ex, ey, ec);
                end
                vec++;
                if (frame_done !== (n == 128)) begin
                    err++;
                    $display("FAIL resume_done n=%0d got %b want %b", n, frame_done, n == 128);
                end
                n++;
            end
        end
        vec++;
        if ({cyc, frame_cnt} !== {32'd107, 8'd1}) begin
            err++;
            $display("FAIL resume_cycles got cyc=%0d cnt=%0d want 107 1", cyc, frame_cnt);
        end
        vec++;
        if (gfx_valid !== 1'b1) begin
            err++;
            $display("FAIL pre_reset_valid got %b want 1", gfx_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        vec++;
        if ({gfx_x, gfx_y, gfx_color, gfx_valid, busy, frame_done, frame_cnt} !== 30'd0) begin
            err++;
            $display("FAIL async_reset got x=%0d y=%0d c=%h v=%b busy=%b done=%b cnt=%0d want all 0", gfx_x, gfx_y, gfx_color, gfx_valid, busy, frame_done, frame_cnt);
        end
        #1;
        reset = 1'b0;
        mode = 2'd0;
        frames = 8'd1;
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 100) begin
            tick;
            cyc++;
            if (gfx_valid) begin
                vec++;
                if ({gfx_x, gfx_y, gfx_color} !== {4'(n), 3'd0, 12'(n)}) begin
                    err++;
                    $display("FAIL restart_beat n=%0d got (%0d,%0d,%h) want (%0d,0,%h)", n, gfx_x, gfx_y, gfx_color, n, 12'(n));
                end
                if (n == 15)
                    enable = 1'b0;
                n++;
            end
        end
        vec++;
        if (cyc !== 16) begin
            err++;
            $display("FAIL restart_cycles got %0d want 16", cyc);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_linear;
        test_stride2;
        test_stride3;
        test_backpressure;
        test_random;
        test_solid_pause_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
